dac_cmd_seq: RTL and testbench
==============================

# dac_cmd_seq

Command sequencer that sits directly upstream of the AD5632 serial DAC driver. It accepts channel setpoint writes from the local register bus and formats them into 24-bit AD5632 frames. Frames are queued in a small FIFO and released to the driver as a `cmd_dat`/`cmd_str` pulse only after the previous frame has had time to shift out and latch. The driver has no busy output, so this block owns inter-frame pacing by counting the same `xtm_trg`/`xtm_clk` falling-edge events the driver uses.

## Interface
- `FRAME_EDGES`, default 28: qualifying serial-clock events to wait after each `cmd_str` before the next may issue (driver needs 27; 1 margin).
- `FIFO_AW`, default 2: FIFO address width; depth = 2^FIFO_AW = 4 entries.
- `bpclk`  in  1  system clock; all logic on rising edge.
- `lreset`  in  1  reset, synchronous, active-high (1 = reset).
- `xtm_trg`  in  1  serial-clock transition strobe, shared with the DAC driver.
- `xtm_clk`  in  1  serial clock level, shared with the DAC driver.
- `wr_en`  in  1  one-cycle write strobe.
- `wr_addr`  in  2  0 = ch A write+update, 1 = ch B write+update, 2 = both channels write+update, 3 = DAC software reset.
- `wr_dat`  in  12  setpoint code for addr 0–2; addr 3 uses bit 0 only (1 = full power-on reset).
- `cmd_dat`  out  32  frame to the DAC driver, registered.
- `cmd_str`  out  1  one-cycle frame strobe to the DAC driver.
- `busy`  out  1  FIFO non-empty or sequencer not IDLE.
- `ovf`  out  1  one-cycle pulse when a write is dropped because the FIFO is full.

## Operation
- Frame format: `cmd_dat[31:22]` = 0, `[21:19]` = command, `[18:16]` = address, `[15:4]` = data, `[3:0]` = 0.
- Addr 0 encodes as command 011, address 000, data `wr_dat`.
- Addr 1 encodes as command 011, address 001, data `wr_dat`.
- Addr 2 encodes as command 011, address 111, data `wr_dat`.
- Addr 3 encodes as command 101, address 000, `[15:1]` = 0, `[0]` = `wr_dat[0]`.
- Formatting happens at write time; the FIFO stores 24-bit frames (`[23:0]`).
- FIFO ordering: strict first-in first-out; no coalescing of repeated writes to the same channel.
- Write while full is dropped and pulses `ovf` for one cycle. If a pop occurs in the same cycle, the write is accepted and `ovf` stays 0.
- Qualifying event: a cycle with `xtm_trg && !xtm_clk`.
- State IDLE: if the FIFO is non-empty, pop the head, load `cmd_dat`, go to ISSUE.
- State ISSUE: `cmd_str` = 1 for this cycle only; load the edge counter with `FRAME_EDGES`; go to WAIT.
- State WAIT: decrement the counter on each qualifying event. When it decrements from 1 to 0, go to IDLE on the next cycle.
- `cmd_dat` holds its value from ISSUE until the next pop. It is never changed while the driver may be sampling it.
- Counter width is $clog2(FRAME_EDGES+1). The counter never wraps below 0.
- Qualifying events in IDLE or ISSUE are ignored and not counted.

## Timing
- Reset values: `cmd_dat` = 0, `cmd_str` = 0, `busy` = 0, `ovf` = 0. FIFO is emptied, state = IDLE, counter = 0.
- Reset mid-frame aborts WAIT immediately; queued frames are discarded.
- Latency: `wr_en` in cycle N with the FIFO empty and state IDLE gives the entry visible in N+1, pop in N+1, and `cmd_str` = 1 in N+2 with `cmd_dat` valid the same cycle.
- Inter-frame spacing: the next `cmd_str` comes no earlier than 2 cycles after the `FRAME_EDGES`-th qualifying event following the previous `cmd_str`.
- `busy` rises the cycle after the accepted write and falls the cycle after WAIT exits with the FIFO empty.
- `ovf` is asserted the cycle after the rejected `wr_en`.

## Test plan
- Reset, then write addr 0 with data 12'hABC. Expect `cmd_str` exactly 2 cycles later with `cmd_dat` = 32'h0018ABC0, and `busy` high until 28 events plus 1 cycle.
- Write addr 1 = 12'h123, addr 2 = 12'hFFF, addr 3 = 12'h001 back-to-back. Expect three strobes in that order: 32'h00191230, 32'h001FFFF0, 32'h00280001. Each pair must be separated by at least 28 qualifying events.
- Issue 6 writes while the first frame waits. Expect 4 accepted after the initial pop, and `ovf` pulses exactly once, for the 6th.
- Full FIFO with a write coinciding with the pop cycle: expect the write accepted, `ovf` = 0, and all 5 frames emitted.
- Hold `xtm_trg` = 0 after `cmd_str`: expect no second `cmd_str` ever. Then apply events with `xtm_clk` = 1: expect them not counted.
- Assert `lreset` during WAIT with 3 frames queued: expect all outputs at reset values next cycle and no further `cmd_str` after release.

Source files
------------

// File: rtl/dac_cmd_seq.sv
// dac_cmd_seq: formats register writes into AD5632 frames, queues them and paces their release to the DAC driver
module dac_cmd_seq #(
    parameter int FRAME_EDGES = 28,
    parameter int FIFO_AW     = 2
) (
    input  logic        bpclk,
    input  logic        lreset,
    input  logic        xtm_trg,
    input  logic        xtm_clk,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [11:0] wr_dat,
    output logic [31:0] cmd_dat,
    output logic        cmd_str,
    output logic        busy,
    output logic        ovf
);
    localparam int CW    = $clog2(FRAME_EDGES + 1);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t             state;
    logic [23:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
    logic [FIFO_AW:0]   count;
    logic [CW-1:0]      cnt;
    logic [23:0]        frame;
    logic               qual, empty, full, pop, push;
    assign qual  = xtm_trg && !xtm_clk;
    assign empty = count == '0;
    assign full  = count[FIFO_AW];
    assign pop   = state == IDLE && !empty;
    assign push  = wr_en && (!full || pop);
    assign busy  = !empty || state != IDLE;
    // frame encoding at write time: software reset uses bit 0, the rest are write+update commands
    always_comb begin
        frame = wr_addr == 2'd3 ? {2'b00, 3'b101, 3'b000, 15'd0, wr_dat[0]}
                                : {2'b00, 3'b011, (wr_addr == 2'd2 ? 3'b111 : {2'b00, wr_addr[0]}), wr_dat, 4'h0};
    end
    // frame storage; contents need no reset because the pointers guard them
    always_ff @(posedge bpclk) begin
        if (push)
            mem[wr_ptr] <= frame;
    end
    // FIFO pointers, occupancy and the dropped-write pulse
    always_ff @(posedge bpclk) begin
        if (lreset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            rd_ptr <= pop ? rd_ptr + FIFO_AW'(1) : rd_ptr;
            wr_ptr <= push ? wr_ptr + FIFO_AW'(1) : wr_ptr;
            count  <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            ovf    <= wr_en && full && !pop;
        end
    end
    // issue sequencer: pop, strobe once, then hold off until the frame has shifted out
    always_ff @(posedge bpclk) begin
        if (lreset) begin
            state   <= IDLE;
            cnt     <= '0;
            cmd_dat <= '0;
            cmd_str <= 1'b0;
        end else begin
            cmd_str <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        cmd_dat <= {8'h00, mem[rd_ptr]};
                        cmd_str <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CW'(FRAME_EDGES);
                    state <= WAIT;
                end
                WAIT: begin
                    if (qual && cnt != '0) begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_cmd_seq.sv
// tb_dac_cmd_seq: directed checks of framing, pacing, overflow and reset behaviour
module tb_dac_cmd_seq;
    logic        bpclk = 0, lreset = 1, xtm_trg = 0, xtm_clk = 0, wr_en = 0;
    logic [1:0]  wr_addr = 0;
    logic [11:0] wr_dat = 0;
    logic [31:0] cmd_dat;
    logic        cmd_str, busy, ovf;
    int          errors = 0, checks = 0, ev_since = 0;
    logic [31:0] got[$];
    int          gaps[$];

    always #5 bpclk = ~bpclk;

    dac_cmd_seq dut (
        .bpclk(bpclk), .lreset(lreset), .xtm_trg(xtm_trg), .xtm_clk(xtm_clk),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat),
        .cmd_dat(cmd_dat), .cmd_str(cmd_str), .busy(busy), .ovf(ovf)
    );

    // strobe log with the number of qualifying inputs seen since the previous strobe
    always @(negedge bpclk) begin
        if (lreset)
            ev_since = 0;
        else if (cmd_str) begin
            got.push_back(cmd_dat);
            gaps.push_back(ev_since);
            ev_since = 0;
        end else if (xtm_trg && !xtm_clk)
            ev_since++;
    end

    task automatic cyc();
        @(negedge bpclk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [11:0] d);
        wr_en = 1; wr_addr = a; wr_dat = d;
        cyc();
        wr_en = 0;
    endtask

    task automatic do_reset();
        lreset = 1; xtm_trg = 0; xtm_clk = 0; wr_en = 0;
        cyc(); cyc();
        lreset = 0;
        got.delete(); gaps.delete();
    endtask

    task automatic test_reset();
        lreset = 1; wr_en = 1; wr_addr = 0; wr_dat = 12'hFFF;
        cyc(); cyc();
        wr_en = 0;
        checks++; if (cmd_dat !== 32'h0) begin errors++; $display("FAIL reset_cmd_dat got=%h exp=0", cmd_dat); end
        checks++; if (cmd_str !== 1'b0) begin errors++; $display("FAIL reset_cmd_str got=%b exp=0", cmd_str); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        wr(2'd0, 12'hABC);
        checks++; if (busy !== 1'b1 || cmd_str !== 1'b0) begin errors++; $display("FAIL single_n1 busy=%b str=%b exp busy=1 str=0", busy, cmd_str); end
        cyc();
        checks++; if (cmd_str !== 1'b1) begin errors++; $display("FAIL single_strobe got=%b exp=1", cmd_str); end
        checks++; if (cmd_dat !== 32'h0018ABC0) begin errors++; $display("FAIL single_dat got=%h exp=0018abc0", cmd_dat); end
        xtm_trg = 1; xtm_clk = 0;
        for (int i = 0; i < 28; i++) begin
            cyc();
            checks++; if (busy !== 1'b1 || cmd_str !== 1'b0) begin errors++; $display("FAIL single_wait[%0d] busy=%b str=%b exp busy=1 str=0", i, busy, cmd_str); end
        end
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
        xtm_trg = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        xtm_trg = 1; xtm_clk = 0;
        wr(2'd1, 12'h123);
        wr(2'd2, 12'hFFF);
        wr(2'd3, 12'h001);
        repeat (120) cyc();
        xtm_trg = 0;
        checks++;
        if (got.size() != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
        else begin
            checks++; if (got[0] !== 32'h00191230) begin errors++; $display("FAIL b2b_f0 got=%h exp=00191230", got[0]); end
            checks++; if (got[1] !== 32'h001FFFF0) begin errors++; $display("FAIL b2b_f1 got=%h exp=001ffff0", got[1]); end
            checks++; if (got[2] !== 32'h00280001) begin errors++; $display("FAIL b2b_f2 got=%h exp=00280001", got[2]); end
            checks++; if (gaps[1] != 29) begin errors++; $display("FAIL b2b_gap1 got=%0d exp=29", gaps[1]); end
            checks++; if (gaps[2] != 29) begin errors++; $display("FAIL b2b_gap2 got=%0d exp=29", gaps[2]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1; wr_addr = 0; wr_dat = 12'h100 + 12'(i);
            cyc();
            checks++; if (ovf !== (i == 5)) begin errors++; $display("FAIL ovf_w%0d got=%b exp=%b", i, ovf, i == 5); end
        end
        wr_en = 0;
        cyc();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
        xtm_trg = 1; xtm_clk = 0;
        repeat (200) cyc();
        xtm_trg = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_idle busy=%b exp=0", busy); end
        checks++;
        if (got.size() != 5) begin errors++; $display("FAIL ovf_count got=%0d exp=5", got.size()); end
        else for (int i = 0; i < 5; i++) begin
            checks++; if (got[i] !== 32'h00181000 + 32'(i * 16)) begin errors++; $display("FAIL ovf_f%0d got=%h exp=%h", i, got[i], 32'h00181000 + 32'(i * 16)); end
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wr_addr = 0; wr_dat = 12'h200 + 12'(i);
            cyc();
        end
        wr_en = 0; xtm_trg = 1; xtm_clk = 0;
        repeat (28) cyc();
        checks++; if (got.size() != 1) begin errors++; $display("FAIL fullpop_pre got=%0d exp=1", got.size()); end
        wr_en = 1; wr_addr = 0; wr_dat = 12'h205;
        cyc();
        wr_en = 0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got=%b exp=0", ovf); end
        checks++; if (cmd_str !== 1'b1 || cmd_dat !== 32'h00182010) begin errors++; $display("FAIL fullpop_strobe str=%b dat=%h exp str=1 dat=00182010", cmd_str, cmd_dat); end
        repeat (250) cyc();
        xtm_trg = 0;
        checks++;
        if (got.size() != 6) begin errors++; $display("FAIL fullpop_count got=%0d exp=6", got.size()); end
        else for (int i = 0; i < 6; i++) begin
            checks++; if (got[i] !== 32'h00182000 + 32'(i * 16)) begin errors++; $display("FAIL fullpop_f%0d got=%h exp=%h", i, got[i], 32'h00182000 + 32'(i * 16)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        wr(2'd0, 12'h055);
        wr(2'd1, 12'h066);
        repeat (60) cyc();
        checks++; if (got.size() != 1 || busy !== 1'b1) begin errors++; $display("FAIL stall_notrg strobes=%0d busy=%b exp strobes=1 busy=1", got.size(), busy); end
        xtm_trg = 1; xtm_clk = 1;
        repeat (60) cyc();
        checks++; if (got.size() != 1) begin errors++; $display("FAIL stall_clkhigh strobes=%0d exp=1", got.size()); end
        xtm_clk = 0;
        repeat (40) cyc();
        xtm_trg = 0;
        checks++;
        if (got.size() != 2) begin errors++; $display("FAIL stall_resume strobes=%0d exp=2", got.size()); end
        else begin
            checks++; if (got[0] !== 32'h00180550) begin errors++; $display("FAIL stall_f0 got=%h exp=00180550", got[0]); end
            checks++; if (got[1] !== 32'h00190660) begin errors++; $display("FAIL stall_f1 got=%h exp=00190660", got[1]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        xtm_trg = 1; xtm_clk = 0;
        for (int i = 0; i < 4; i++) wr(2'd0, 12'h300 + 12'(i));
        repeat (5) cyc();
        checks++; if (got.size() != 1 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre strobes=%0d busy=%b exp strobes=1 busy=1", got.size(), busy); end
        lreset = 1;
        cyc();
        checks++; if (cmd_dat !== 32'h0 || cmd_str !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rstmid_out dat=%h str=%b busy=%b ovf=%b exp all 0", cmd_dat, cmd_str, busy, ovf); end
        lreset = 0;
        repeat (100) cyc();
        xtm_trg = 0;
        checks++; if (got.size() != 1) begin errors++; $display("FAIL rstmid_after strobes=%0d exp=1", got.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
